seq_stage_controller: RTL and testbench
=======================================

// Module: seq_stage_controller
// PURPOSE
//  Sequencing FSM for the Y86-64 SEQ core: steps one instruction through FETCH,
//  DECODE, EXECUTE, MEMORY, WRITEBACK and PC_UPDATE, one enable per stage.
//  Owns the architectural PC and the Y86 status code, and waits on the data-memory
//  handshake. Sits above the fetch/decode/execute/memory/writeback units.
// PARAMETERS
//  PC_W        64  width of PC and next_pc
//  RESET_PC    0   PC value loaded on reset
//  CNT_W       32  width of cycle_count / retired_count
//  MEM_TIMEOUT 15  max MEMORY wait cycles before ADR fault (>=1)
// PORTS
//  clock             in   1     rising-edge clock
//  reset             in   1     synchronous, active-high
//  start             in   1     pulse: leave IDLE, begin at pc
//  icode             in   4     from fetch
//  instruction_valid in   1     from fetch
//  imem_error        in   1     from fetch
//  next_pc           in   PC_W  external PC-select result (valP/valC/valM)
//  dmem_ready        in   1     data memory access complete (sampled in MEMORY)
//  dmem_error        in   1     data memory address fault, qualified by dmem_ready
//  pc                out  PC_W  registered architectural PC, drives fetch
//  fetch_en..pc_update_en out 1 each: six one-hot stage enables
//  memory_en         out  1     high in MEMORY only for memory-op icodes
//  stat              out  3     1=AOK 2=HLT 3=ADR 4=INS
//  busy              out  1     state not IDLE/HALTED
//  cycle_count       out  CNT_W cycles spent busy, saturating
//  retired_count     out  CNT_W instructions completed PC_UPDATE, saturating
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, stat=AOK, counters=0. All enables are 0.
//  Reset mid-instruction aborts the instruction, with no partial effects.
//  States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED.
//  Enables decode combinationally from state; only the enable of the current stage is high.
//  IDLE: start=1 -> FETCH next cycle. start is ignored in every other state.
//  FETCH, end of cycle, priority order:
//   imem_error -> stat=ADR, HALTED; else !instruction_valid -> stat=INS, HALTED;
//   else icode==0 (halt) -> stat=HLT, HALTED; else -> DECODE.
//   In all fault/halt cases pc is unchanged and retired_count is unchanged.
//  DECODE -> EXECUTE -> MEMORY: one cycle each.
//  MEMORY, memory ops (icode 4,5,8,9,A,B): memory_en held high.
//   Stay in MEMORY until dmem_ready=1.
//   dmem_ready&dmem_error -> stat=ADR, HALTED, no WRITEBACK, pc unchanged.
//   dmem_ready&!dmem_error -> WRITEBACK.
//   No dmem_ready within MEM_TIMEOUT MEMORY cycles -> stat=ADR, HALTED.
//  MEMORY, other icodes: memory_en=0; one cycle, then WRITEBACK.
//  WRITEBACK -> PCUPD. PCUPD: pc<=next_pc, retired_count+1, -> FETCH.
//  Latency: 6 cycles per non-memory instruction; memory ops take 6 + wait cycles.
//   Back-to-back: FETCH of instr n+1 follows PCUPD of n.
//  HALTED: terminal; stat/pc hold; only reset exits.
//  cycle_count increments every busy cycle. Both counters saturate at all-ones.
//  PC wraps naturally if next_pc wraps; controller does no PC arithmetic.
// TESTING
//  1 reset,start; icode=6 valid, next_pc=2 -> enables walk F,D,E,M,W,PU, one cycle each;
//    pc=2 and retired=1 after 6 cycles; memory_en stays 0.
//  2 icode=5, dmem_ready rises on 4th MEMORY cycle -> memory_en high 4 cycles;
//    PCUPD on cycle 9; cycle_count=9.
//  3 icode=0 at pc=0x14 -> stat=2, HALTED, pc=0x14, retired unchanged;
//    start pulse then ignored.
//  4 imem_error=1 with instruction_valid=0 -> stat=3 (ADR wins);
//    rerun with imem_error=0, instruction_valid=0 -> stat=4.
//  5 icode=A, dmem_ready held 0 -> ADR after exactly 15 MEMORY cycles;
//    rerun with dmem_ready=1, dmem_error=1 -> ADR, writeback_en never high.
//  6 reset pulse during EXECUTE of 2nd instr -> next cycle IDLE, pc=0, stat=1,
//    counters 0, all enables 0.

Source files
------------

// File: rtl/seq_stage_controller.sv
// Sequencing FSM for the Y86-64 SEQ core: walks each instruction through the six
// stages, owns the architectural PC and status code, and waits on data memory.
module seq_stage_controller #(
    parameter int unsigned     PC_W        = 64,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int unsigned     CNT_W       = 32,
    parameter int unsigned     MEM_TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instruction_valid,
    input  logic             imem_error,
    input  logic [PC_W-1:0]  next_pc,
    input  logic             dmem_ready,
    input  logic             dmem_error,
    output logic [PC_W-1:0]  pc,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_stage_en,
    output logic             writeback_en,
    output logic             pc_update_en,
    output logic             memory_en,
    output logic [2:0]       stat,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    localparam int unsigned TMR_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALTED
    } state_t;

    state_t           state, state_next;
    logic [2:0]       stat_next;
    logic [3:0]       icode_q;
    logic [TMR_W-1:0] mem_tmr;
    logic             icode_load, tmr_inc, pc_load, mem_op;

    // icode captured at the end of FETCH so the MEMORY decision ignores later fetch activity
    always_comb begin
        case (icode_q)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: mem_op = 1'b1;
            default:                            mem_op = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        stat_next  = stat;
        icode_load = 1'b0;
        tmr_inc    = 1'b0;
        pc_load    = 1'b0;
        case (state)
            S_IDLE: if (start) state_next = S_FETCH;
            S_FETCH: begin
                if (imem_error) begin
                    stat_next  = STAT_ADR;
                    state_next = S_HALTED;
                end else if (!instruction_valid) begin
                    stat_next  = STAT_INS;
                    state_next = S_HALTED;
                end else if (icode == 4'h0) begin
                    stat_next  = STAT_HLT;
                    state_next = S_HALTED;
                end else begin
                    icode_load = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE:  state_next = S_EXECUTE;
            S_EXECUTE: state_next = S_MEMORY;
            S_MEMORY: begin
                if (!mem_op) begin
                    state_next = S_WRITEBACK;
                end else if (dmem_ready) begin
                    if (dmem_error) begin
                        stat_next  = STAT_ADR;
                        state_next = S_HALTED;
                    end else begin
                        state_next = S_WRITEBACK;
                    end
                end else if (mem_tmr == TMR_W'(MEM_TIMEOUT - 1)) begin
                    stat_next  = STAT_ADR;
                    state_next = S_HALTED;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            S_WRITEBACK: state_next = S_PCUPD;
            S_PCUPD: begin
                pc_load    = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = state;
        endcase
    end

    // Architectural state; reset aborts any in-flight instruction
    always_ff @(posedge clock) begin
        if (reset) begin
            pc            <= RESET_PC;
            stat          <= STAT_AOK;
            icode_q       <= 4'h0;
            mem_tmr       <= '0;
            cycle_count   <= '0;
            retired_count <= '0;
        end else begin
            stat <= stat_next;
            if (icode_load) icode_q <= icode;
            if (state != S_MEMORY) mem_tmr <= '0;
            else if (tmr_inc)      mem_tmr <= mem_tmr + TMR_W'(1);
            if (pc_load) begin
                pc <= next_pc;
                if (retired_count != '1) retired_count <= retired_count + CNT_W'(1);
            end
            if (busy && cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
        end
    end

    assign fetch_en        = (state == S_FETCH);
    assign decode_en       = (state == S_DECODE);
    assign execute_en      = (state == S_EXECUTE);
    assign memory_stage_en = (state == S_MEMORY);
    assign writeback_en    = (state == S_WRITEBACK);
    assign pc_update_en    = (state == S_PCUPD);
    assign memory_en       = (state == S_MEMORY) && mem_op;
    assign busy            = (state != S_IDLE) && (state != S_HALTED);

endmodule

// File: tb/tb_seq_stage_controller.sv
// Directed-vector bench for seq_stage_controller: stage walk, memory waits,
// halt/fault paths, timeout and mid-instruction reset.
module tb_seq_stage_controller;

    logic        clock = 1'b0;
    logic        reset, start, instruction_valid, imem_error, dmem_ready, dmem_error;
    logic [3:0]  icode;
    logic [63:0] next_pc, pc;
    logic        fetch_en, decode_en, execute_en, memory_stage_en, writeback_en, pc_update_en;
    logic        memory_en, busy;
    logic [2:0]  stat;
    logic [31:0] cycle_count, retired_count;
    logic [5:0]  en;

    int checks = 0;
    int errors = 0;

    seq_stage_controller dut (
        .clock(clock), .reset(reset), .start(start), .icode(icode),
        .instruction_valid(instruction_valid), .imem_error(imem_error),
        .next_pc(next_pc), .dmem_ready(dmem_ready), .dmem_error(dmem_error),
        .pc(pc), .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
        .memory_stage_en(memory_stage_en), .writeback_en(writeback_en),
        .pc_update_en(pc_update_en), .memory_en(memory_en), .stat(stat), .busy(busy),
        .cycle_count(cycle_count), .retired_count(retired_count)
    );

    always #5 clock = ~clock;
    assign en = {fetch_en, decode_en, execute_en, memory_stage_en, writeback_en, pc_update_en};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; icode = 4'h6; instruction_valid = 1'b1;
        imem_error = 1'b0; next_pc = 64'h0; dmem_ready = 1'b0; dmem_error = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc !== 64'h0) begin errors++; $display("FAIL reset_pc: got %0h expected 0", pc); end
        checks++; if (stat !== 3'd1) begin errors++; $display("FAIL reset_stat: got %0d expected 1", stat); end
        checks++; if (en !== 6'b0 || memory_en !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_enables: got en=%b mem=%b busy=%b expected all 0", en, memory_en, busy); end
        checks++; if (cycle_count !== 32'd0 || retired_count !== 32'd0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", cycle_count, retired_count); end
        // start ignored-when-not-pulsed: staying idle for a cycle leaves busy low
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_hold: got busy=%b expected 0", busy); end
    endtask

    task automatic test_alu_walk();
        do_reset();
        icode = 4'h6; next_pc = 64'h2;
        launch();
        for (int i = 0; i < 6; i++) begin
            checks++; if (en !== (6'b100000 >> i)) begin
                errors++; $display("FAIL alu_walk_%0d: got %b expected %b", i, en, 6'b100000 >> i); end
            checks++; if (memory_en !== 1'b0) begin
                errors++; $display("FAIL alu_memen_%0d: got %b expected 0", i, memory_en); end
            tick();
        end
        checks++; if (pc !== 64'h2) begin errors++; $display("FAIL alu_pc: got %0h expected 2", pc); end
        checks++; if (retired_count !== 32'd1) begin errors++; $display("FAIL alu_retired: got %0d expected 1", retired_count); end
        checks++; if (cycle_count !== 32'd6) begin errors++; $display("FAIL alu_cycles: got %0d expected 6", cycle_count); end
        checks++; if (fetch_en !== 1'b1) begin errors++; $display("FAIL back_to_back_fetch: got %b expected 1", fetch_en); end
    endtask

    task automatic test_mem_wait();
        logic [5:0] exp;
        int mem_hi;
        mem_hi = 0;
        do_reset();
        icode = 4'h5; next_pc = 64'h10;
        launch();
        for (int c = 1; c <= 9; c++) begin
            case (c)
                1: exp = 6'b100000;
                2: exp = 6'b010000;
                3: exp = 6'b001000;
                8: exp = 6'b000010;
                9: exp = 6'b000001;
                default: exp = 6'b000100;
            endcase
            if (c == 7) dmem_ready = 1'b1;
            checks++; if (en !== exp) begin errors++; $display("FAIL mem_walk_%0d: got %b expected %b", c, en, exp); end
            if (memory_en === 1'b1) mem_hi++;
            tick();
            dmem_ready = 1'b0;
        end
        checks++; if (mem_hi != 4) begin errors++; $display("FAIL mem_en_cycles: got %0d expected 4", mem_hi); end
        checks++; if (cycle_count !== 32'd9) begin errors++; $display("FAIL mem_cycles: got %0d expected 9", cycle_count); end
        checks++; if (pc !== 64'h10 || retired_count !== 32'd1) begin
            errors++; $display("FAIL mem_retire: got pc=%0h ret=%0d expected 10/1", pc, retired_count); end
    endtask

    task automatic test_halt();
        do_reset();
        icode = 4'h6; next_pc = 64'h14;
        launch();
        tick();
        icode = 4'h0;
        repeat (5) tick();
        checks++; if (fetch_en !== 1'b1 || pc !== 64'h14) begin
            errors++; $display("FAIL halt_setup: got fetch=%b pc=%0h expected 1/14", fetch_en, pc); end
        tick();
        checks++; if (stat !== 3'd2) begin errors++; $display("FAIL halt_stat: got %0d expected 2", stat); end
        checks++; if (pc !== 64'h14 || retired_count !== 32'd1) begin
            errors++; $display("FAIL halt_pc: got pc=%0h ret=%0d expected 14/1", pc, retired_count); end
        checks++; if (busy !== 1'b0 || en !== 6'b0) begin
            errors++; $display("FAIL halt_idle: got busy=%b en=%b expected 0/0", busy, en); end
        launch();
        tick();
        checks++; if (busy !== 1'b0 || en !== 6'b0 || stat !== 3'd2 || cycle_count !== 32'd7) begin
            errors++; $display("FAIL halt_start_ignored: got busy=%b en=%b stat=%0d cyc=%0d expected 0/0/2/7",
                               busy, en, stat, cycle_count); end
    endtask

    task automatic test_fetch_faults();
        do_reset();
        imem_error = 1'b1; instruction_valid = 1'b0;
        launch();
        tick();
        checks++; if (stat !== 3'd3) begin errors++; $display("FAIL imem_adr: got %0d expected 3", stat); end
        checks++; if (pc !== 64'h0 || retired_count !== 32'd0) begin
            errors++; $display("FAIL imem_pc: got pc=%0h ret=%0d expected 0/0", pc, retired_count); end
        do_reset();
        instruction_valid = 1'b0;
        launch();
        tick();
        checks++; if (stat !== 3'd4) begin errors++; $display("FAIL invalid_ins: got %0d expected 4", stat); end
    endtask

    task automatic test_mem_faults();
        int wb_seen;
        wb_seen = 0;
        do_reset();
        icode = 4'hA;
        launch();
        repeat (3) tick();
        for (int i = 0; i < 15; i++) begin
            checks++; if (memory_stage_en !== 1'b1 || memory_en !== 1'b1) begin
                errors++; $display("FAIL timeout_wait_%0d: got stage=%b mem=%b expected 1/1", i, memory_stage_en, memory_en); end
            tick();
        end
        checks++; if (stat !== 3'd3 || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_adr: got stat=%0d busy=%b expected 3/0", stat, busy); end
        checks++; if (retired_count !== 32'd0 || pc !== 64'h0) begin
            errors++; $display("FAIL timeout_no_retire: got ret=%0d pc=%0h expected 0/0", retired_count, pc); end
        do_reset();
        icode = 4'hA; dmem_ready = 1'b1; dmem_error = 1'b1; next_pc = 64'h40;
        launch();
        for (int i = 0; i < 8; i++) begin
            if (writeback_en === 1'b1) wb_seen++;
            tick();
        end
        checks++; if (stat !== 3'd3 || pc !== 64'h0) begin
            errors++; $display("FAIL dmem_err_adr: got stat=%0d pc=%0h expected 3/0", stat, pc); end
        checks++; if (wb_seen != 0) begin errors++; $display("FAIL dmem_err_no_wb: got %0d expected 0", wb_seen); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        icode = 4'h6; next_pc = 64'h8;
        launch();
        repeat (8) tick();
        checks++; if (execute_en !== 1'b1 || pc !== 64'h8) begin
            errors++; $display("FAIL mid_setup: got exe=%b pc=%0h expected 1/8", execute_en, pc); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (pc !== 64'h0 || stat !== 3'd1) begin
            errors++; $display("FAIL mid_reset_pc_stat: got pc=%0h stat=%0d expected 0/1", pc, stat); end
        checks++; if (cycle_count !== 32'd0 || retired_count !== 32'd0) begin
            errors++; $display("FAIL mid_reset_counters: got %0d/%0d expected 0/0", cycle_count, retired_count); end
        checks++; if (en !== 6'b0 || memory_en !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset_enables: got en=%b mem=%b busy=%b expected 0", en, memory_en, busy); end
    endtask

    initial begin
        test_reset();
        test_alu_walk();
        test_mem_wait();
        test_halt();
        test_fetch_faults();
        test_mem_faults();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
